// File: rtl/home_pkg.sv
// Shared definitions for the home automation control blocks.
//   ac_state_e  : AC sequencer state encoding (2 bits, visible on state_o)
//   TEMP_W_DEF  : default width of temperature and setpoint values
package home_pkg;

  localparam int TEMP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEAT    = 2'd1,
    COOL    = 2'd2,
    LOCKOUT = 2'd3
  } ac_state_e;

endpackage

// File: rtl/ac_tick_timer.sv
// Loadable tick-driven counter used for compressor run and lockout timing.
// On each tick the count steps by one toward limit_i (up or down, chosen by
// COUNT_UP) and stays there once reached. Load wins over a same-edge tick, so
// the first tick counted is the one after the load.
//   clk_i, rst_ni : clock, async active-low reset (count clears to 0)
//   load_i        : load load_val_i into the count
//   load_val_i    : value loaded on load_i
//   limit_i       : terminal value; count saturates here
//   tick_i        : count enable
//   done_o        : count == limit_i
module ac_tick_timer #(
  parameter int CNT_W    = 8,
  parameter bit COUNT_UP = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             tick_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (tick_i && (cnt_q != limit_i)) begin
      cnt_q <= COUNT_UP ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == limit_i);

endmodule

// File: rtl/ac_climate_sequencer.sv
// Heat/cool sequencer with hysteresis and compressor protection.
// Compares the latched room temperature with the setpoint, requests heat or
// cool (never both), holds each run for at least MIN_ON ticks unless energy
// saving forces a stop, and enforces MIN_OFF ticks of lockout after any stop.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | no demand, or energy saving holds the AC off
//   HEAT    | heat request active, run timer counting
//   COOL    | cool request active, run timer counting
//   LOCKOUT | compressor rest after a stop, lockout timer counting
//
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   tick_i         : one-cycle timebase strobe
//   temp_i         : measured temperature, latched when temp_valid_i = 1
//   temp_valid_i   : temp_i valid this cycle
//   setpoint_i     : target temperature
//   energy_save_i  : 1 forces the AC off (ignored during LOCKOUT)
//   ac_heat_o      : heat request
//   ac_cool_o      : cool request
//   lockout_o      : 1 while in LOCKOUT
//   state_o        : current state encoding
module ac_climate_sequencer
  import home_pkg::*;
#(
  parameter int TEMP_W  = TEMP_W_DEF,
  parameter int HYST    = 1,
  parameter int MIN_ON  = 3,
  parameter int MIN_OFF = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic [TEMP_W-1:0] temp_i,
  input  logic              temp_valid_i,
  input  logic [TEMP_W-1:0] setpoint_i,
  input  logic              energy_save_i,
  output logic              ac_heat_o,
  output logic              ac_cool_o,
  output logic              lockout_o,
  output logic [1:0]        state_o
);

  localparam logic [TEMP_W:0]  HYST_X    = (TEMP_W+1)'(HYST);
  localparam logic [TEMP_W:0]  TEMP_MAX  = {1'b0, {TEMP_W{1'b1}}};
  localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);

  ac_state_e         state_q, state_d;
  logic [TEMP_W-1:0] temp_q;
  logic              run_load, off_load;
  logic              run_done, off_done;
  logic              running;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      temp_q <= '0;
    end else if (temp_valid_i) begin
      temp_q <= temp_i;
    end
  end

  // Thresholds are one bit wider so setpoint +/- HYST can clamp instead of wrap.
  logic [TEMP_W:0] sp_x, temp_x, lo_x, hi_sum, hi_x;
  logic            too_cold, too_hot;

  always_comb begin
    sp_x     = {1'b0, setpoint_i};
    temp_x   = {1'b0, temp_q};
    lo_x     = (sp_x >= HYST_X) ? (sp_x - HYST_X) : '0;
    hi_sum   = sp_x + HYST_X;
    hi_x     = (hi_sum > TEMP_MAX) ? TEMP_MAX : hi_sum;
    too_cold = (temp_x < lo_x);
    too_hot  = (temp_x > hi_x);
  end

  assign running = (state_q == HEAT) || (state_q == COOL);

  ac_tick_timer #(
    .CNT_W    (CNT_W),
    .COUNT_UP (1'b1)
  ) u_run_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (run_load),
    .load_val_i ('0),
    .limit_i    (MIN_ON_C),
    .tick_i     (tick_i && running),
    .done_o     (run_done)
  );

  ac_tick_timer #(
    .CNT_W    (CNT_W),
    .COUNT_UP (1'b0)
  ) u_off_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (off_load),
    .load_val_i (MIN_OFF_C),
    .limit_i    ('0),
    .tick_i     (tick_i && (state_q == LOCKOUT)),
    .done_o     (off_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_load = 1'b0;
    off_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!energy_save_i) begin
          if (too_cold) begin
            state_d  = HEAT;
            run_load = 1'b1;
          end else if (too_hot) begin
            state_d  = COOL;
            run_load = 1'b1;
          end
        end
      end
      HEAT: begin
        // Energy saving cuts the run short; otherwise MIN_ON must elapse.
        if (energy_save_i || ((temp_q >= setpoint_i) && run_done)) begin
          state_d  = LOCKOUT;
          off_load = 1'b1;
        end
      end
      COOL: begin
        if (energy_save_i || ((temp_q <= setpoint_i) && run_done)) begin
          state_d  = LOCKOUT;
          off_load = 1'b1;
        end
      end
      LOCKOUT: begin
        if (off_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ac_heat_o = (state_q == HEAT);
    ac_cool_o = (state_q == COOL);
    lockout_o = (state_q == LOCKOUT);
    state_o   = state_q;
  end

endmodule
